// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: decode-side request, stall and result.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, ready, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, ready, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / restoring divide unit producing HI/LO results.
// Optional macro MULDIV_SINGLE_CYCLE_MUL_EN: mult/multu complete in one cycle.
module muldiv_unit (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic                is_div, neg_res, neg_rem, div_zero;
  logic [DATA_W-1:0]   opnd, a_raw;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                busy_c, ready_c, accept, fast_mul;
  logic                signed_op, div_op, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] fin_result, fast_prod;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return (v < 0) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Shift-add: upper half accumulates, multiplier bits retire from the bottom.
  function automatic logic [2*DATA_W:0] mul_step(input logic [2*DATA_W:0] w,
                                                 input logic [DATA_W-1:0] mcand);
    logic [DATA_W:0] sum;
    sum = w[0] ? ({1'b0, w[2*DATA_W-1:DATA_W]} + {1'b0, mcand})
               : {1'b0, w[2*DATA_W-1:DATA_W]};
    return {1'b0, sum, w[DATA_W-1:1]};
  endfunction

  // Restoring step: shifted remainder may need 33 bits before the compare.
  function automatic logic [2*DATA_W:0] div_step(input logic [2*DATA_W:0] w,
                                                 input logic [DATA_W-1:0] dvsr);
    logic [2*DATA_W:0] sh;
    logic [DATA_W+1:0] diff;
    sh   = {w[2*DATA_W-1:0], 1'b0};
    diff = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b00, dvsr};
    if (!diff[DATA_W+1])
      return {1'b0, diff[DATA_W-1:0], sh[DATA_W-1:1], 1'b1};
    return sh;
  endfunction

  assign signed_op = ~bus.op[0];
  assign div_op    = bus.op[1];
  assign a_neg     = signed_op & bus.a[DATA_W-1];
  assign b_neg     = signed_op & bus.b[DATA_W-1];
  assign a_mag     = signed_op ? magnitude($signed(bus.a)) : bus.a;
  assign b_mag     = signed_op ? magnitude($signed(bus.b)) : bus.b;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic signed [2*DATA_W-1:0] fm_a, fm_b;

  always_comb begin
    fm_a      = bus.op[0] ? {{DATA_W{1'b0}}, bus.a} : {{DATA_W{bus.a[DATA_W-1]}}, bus.a};
    fm_b      = bus.op[0] ? {{DATA_W{1'b0}}, bus.b} : {{DATA_W{bus.b[DATA_W-1]}}, bus.b};
    fast_prod = fm_a * fm_b;
  end

  assign fast_mul = ~bus.op[1];
`else
  assign fast_prod = '0;
  assign fast_mul  = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.start && !bus.cancel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    ready_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel)
          state_nxt = fast_mul ? DONE : RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1))
          state_nxt = FIN;
      end
      FIN: begin
        busy_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        ready_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.cancel)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == RUN)  cnt <= cnt + 1'b1;
  end

  // Operand capture (IDLE) and one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div   <= div_op;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= div_op && (bus.b == '0);
      a_raw    <= bus.a;
      opnd     <= div_op ? b_mag : a_mag;
      work     <= {{(DATA_W+1){1'b0}}, (div_op ? a_mag : b_mag)};
    end else if (state == RUN) begin
      work <= is_div ? div_step(work, opnd) : mul_step(work, opnd);
    end
  end

  always_comb begin
    if (!is_div)
      fin_result = cond_neg64(work[2*DATA_W-1:0], neg_res);
    else if (div_zero)
      fin_result = {a_raw, {DATA_W{1'b1}}};
    else
      fin_result = {cond_neg32(work[2*DATA_W-1:DATA_W], neg_rem),
                    cond_neg32(work[DATA_W-1:0], neg_res)};
  end

  // Results move only on the FIN edge or the single-cycle multiply edge
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!bus.cancel) begin
      if (state == FIN)
        {hi_q, lo_q} <= fin_result;
      else if (accept && fast_mul)
        {hi_q, lo_q} <= fast_prod;
    end
  end

  assign bus.busy  = busy_c;
  assign bus.ready = ready_c;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, hand-written timing sequences, random ops vs model.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[12];

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    if (!op[1]) return 1;
`endif
    return 34;
  endfunction

  // Reference: plain 64-bit arithmetic plus the two architected special cases.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    int          q, r;
    logic [63:0] res;
    case (op)
      2'd0: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = sa * sb;
      end
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0)                                    res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
        else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0); wait up to 60 cycles for ready.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int rdy, output int busy_bad);
    int lat;
    lat       = exp_lat(op);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    rdy       = -1;
    busy_bad  = 0;
    hi        = '0;
    lo        = '0;
    for (int c = 1; c <= 60 && rdy < 0; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.ready === 1'b1) begin
        rdy = c;
        hi  = bus.hi;
        lo  = bus.lo;
      end
      if (bus.busy !== 1'(c < lat)) busy_bad++;
    end
    step();
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h, l;
    int          rdy, bb;
    do_op(op, a, b, h, l, rdy, bb);
    check({name, "_hi"}, {32'd0, h}, {32'd0, ehi});
    check({name, "_lo"}, {32'd0, l}, {32'd0, elo});
    check({name, "_ready_cycle"}, 64'(rdy), 64'(exp_lat(op)));
    check({name, "_busy_profile_errors"}, 64'(bb), 64'd0);
  endtask

  initial begin
    logic [31:0] h, l, ra, rb;
    logic [1:0]  rop;
    logic [63:0] exp;
    int          nrdy, nbusy, rc, sel;

    tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[2]  = '{2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    tbl[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4]  = '{2'd0, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB};
    tbl[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[7]  = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    tbl[8]  = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    tbl[9]  = '{2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tbl[10] = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tbl[11] = '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};

    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 2'd0;
    bus.a      = '0;
    bus.b      = '0;
    rst        = 1'b1;
    step();
    step();
    check("reset_busy",  64'(bus.busy),  64'd0);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_hi",    {32'd0, bus.hi}, 64'd0);
    check("reset_lo",    {32'd0, bus.lo}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    // Reset in cycle 15 of a multiply clears everything in cycle 16
    bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      bus.start = 1'b0;
      if (c == 15) rst = 1'b1;
    end
    step();
    rst = 1'b0;
    check("rst_flight_busy",  64'(bus.busy),  64'd0);
    check("rst_flight_ready", 64'(bus.ready), 64'd0);
    check("rst_flight_hi",    {32'd0, bus.hi}, 64'd0);
    check("rst_flight_lo",    {32'd0, bus.lo}, 64'd0);

    // Simultaneous start and cancel in IDLE: nothing happens
    bus.op = 2'd3; bus.a = 32'd5; bus.b = 32'd1;
    bus.start = 1'b1; bus.cancel = 1'b1;
    nrdy = 0; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.start = 1'b0; bus.cancel = 1'b0;
      if (bus.ready) nrdy++;
      if (bus.busy)  nbusy++;
    end
    check("startcancel_busy_cycles",  64'(nbusy), 64'd0);
    check("startcancel_ready_cycles", 64'(nrdy),  64'd0);
    check("startcancel_lo",           {32'd0, bus.lo}, 64'd0);

    // Second start in cycle 10 during a divide is ignored
    bus.op = 2'd2; bus.a = 32'h80000000; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
    nrdy = 0; rc = -1; h = '0; l = '0;
    for (int c = 1; c <= 45; c++) begin
      step();
      bus.start = (c == 10);
      if (c == 10) begin bus.op = 2'd3; bus.a = 32'd5; bus.b = 32'd1; end
      if (bus.ready) begin
        nrdy++;
        if (rc < 0) begin rc = c; h = bus.hi; l = bus.lo; end
      end
    end
    check("ignore_start_ready_count", 64'(nrdy), 64'd1);
    check("ignore_start_ready_cycle", 64'(rc),   64'd34);
    check("ignore_start_hi", {32'd0, h}, 64'd0);
    check("ignore_start_lo", {32'd0, l}, 64'h80000000);

    // Cancel in cycle 20 of divu 100/7, then a fresh start in cycle 21
    run_check("prior", 2'd0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB);
    bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    nrdy = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.ready) nrdy++;
      if (c == 20) bus.cancel = 1'b1;
    end
    step();
    bus.cancel = 1'b0;
    if (bus.ready) nrdy++;
    check("cancel_busy",        64'(bus.busy), 64'd0);
    check("cancel_ready_count", 64'(nrdy),     64'd0);
    check("cancel_hi_kept", {32'd0, bus.hi}, 64'hFFFFFFFF);
    check("cancel_lo_kept", {32'd0, bus.lo}, 64'hFFFFFFFB);
    run_check("after_cancel", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      exp = model(rop, ra, rb);
      run_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, exp[63:32], exp[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
